// File: rtl/mem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stream_ctrl
//
// Fill/drain sequencing engine for a single-port synchronous memory
// (WIDTH x DEPTH, wrbar=1 write, wrbar=0 read, read data registered and valid
// the cycle after the read address is presented).
//
// Fill:  after a fill_start pulse, words arriving on the s_* stream are written
//        to consecutive addresses from 0, one per cycle, with no added latency.
//        The fill ends on the word flagged s_last or on the word written to the
//        top address, whichever comes first.
// Drain: after a drain_start pulse (only when at least one word is stored),
//        the stored words are read back in order and presented on the m_*
//        stream, with m_last flagging the last stored word. Each word costs
//        three cycles: address, capture, present.
//
// Handshake rule (both streams): a word moves on a rising edge where valid and
// ready are both high. While m_valid is high and m_ready is low, m_data,
// m_last and mem_addr are held unchanged. s_ready and m_valid are never high
// in the same cycle.
//
// Ports
//   i_clk, i_rst          clock; asynchronous active-high reset
//   i_fill_start          pulse: begin a fill at address 0 (IDLE only)
//   i_drain_start         pulse: begin a drain from address 0 (IDLE only)
//   i_s_valid/i_s_data/i_s_last, o_s_ready   write stream
//   o_m_valid/o_m_data/o_m_last, i_m_ready   read-back stream
//   o_busy                high whenever the engine is not IDLE
//   o_words_stored        words written by the last fill (0..DEPTH)
//   o_mem_addr/o_mem_wdata/o_mem_wrbar       to the memory
//   i_mem_rdata           registered read data from the memory
//   o_state               current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module mem_stream_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int ADDR  = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_fill_start,
  input  logic             i_drain_start,
  input  logic             i_s_valid,
  input  logic [WIDTH-1:0] i_s_data,
  input  logic             i_s_last,
  output logic             o_s_ready,
  output logic             o_m_valid,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_last,
  input  logic             i_m_ready,
  output logic             o_busy,
  output logic [ADDR:0]    o_words_stored,
  output logic [ADDR-1:0]  o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic             o_mem_wrbar,
  input  logic [WIDTH-1:0] i_mem_rdata,
  output logic [2:0]       o_state
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_DRAIN_RD  = 3'd2,
    ST_DRAIN_CAP = 3'd3,
    ST_DRAIN_OUT = 3'd4
  } state_t;

  state_t            r_state;
  logic [ADDR-1:0]   r_wptr;
  logic [ADDR-1:0]   r_rptr;
  logic [ADDR:0]     r_words_stored;
  logic              r_s_ready;
  logic              r_m_valid;
  logic              r_m_last;
  logic [WIDTH-1:0]  r_m_data;
  logic              r_busy;

  logic              w_accept;
  logic              w_at_top;
  logic              w_fill_end;
  logic              w_rd_last;
  logic              w_out_hs;
  logic              w_draining;

  // r_s_ready is high exactly while in FILL, so accept needs no state decode.
  assign w_accept   = r_s_ready & i_s_valid;
  // The top address ends the fill even without s_last; wptr never wraps.
  assign w_at_top   = (r_wptr == ADDR'(DEPTH - 1));
  assign w_fill_end = w_accept & (i_s_last | w_at_top);
  // Evaluated in DRAIN_CAP, so m_last is registered alongside m_data.
  assign w_rd_last  = (({1'b0, r_rptr} + {{ADDR{1'b0}}, 1'b1}) == r_words_stored);
  assign w_out_hs   = r_m_valid & i_m_ready;
  assign w_draining = (r_state == ST_DRAIN_RD) || (r_state == ST_DRAIN_CAP) ||
                      (r_state == ST_DRAIN_OUT);

  // Memory port is combinational so an accepted word is written on the very
  // edge that accepts it (zero added write latency). During a drain the read
  // address is rptr, which only moves on an output handshake, so it stays
  // stable through capture and any backpressure.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_wrbar = 1'b0;
    if (w_accept) begin
      o_mem_addr  = r_wptr;
      o_mem_wdata = i_s_data;
      o_mem_wrbar = 1'b1;
    end else if (w_draining) begin
      o_mem_addr  = r_rptr;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_words_stored <= '0;
      r_s_ready      <= 1'b0;
      r_m_valid      <= 1'b0;
      r_m_last       <= 1'b0;
      r_m_data       <= '0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Fill takes priority over drain when both pulse together.
          if (i_fill_start) begin
            r_state        <= ST_FILL;
            r_wptr         <= '0;
            r_words_stored <= '0;
            r_s_ready      <= 1'b1;
            r_busy         <= 1'b1;
          end else if (i_drain_start && (r_words_stored != '0)) begin
            r_state <= ST_DRAIN_RD;
            r_rptr  <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_FILL: begin
          if (w_accept) begin
            r_words_stored <= r_words_stored + {{ADDR{1'b0}}, 1'b1};
            if (!w_at_top) begin
              r_wptr <= r_wptr + {{(ADDR-1){1'b0}}, 1'b1};
            end
          end
          if (w_fill_end) begin
            r_state   <= ST_IDLE;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
          end
        end

        ST_DRAIN_RD: begin
          // Address is presented this cycle; the memory registers the data.
          r_state <= ST_DRAIN_CAP;
        end

        ST_DRAIN_CAP: begin
          r_m_data  <= i_mem_rdata;
          r_m_last  <= w_rd_last;
          r_m_valid <= 1'b1;
          r_state   <= ST_DRAIN_OUT;
        end

        ST_DRAIN_OUT: begin
          if (w_out_hs) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
            if (r_m_last) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_rptr  <= r_rptr + {{(ADDR-1){1'b0}}, 1'b1};
              r_state <= ST_DRAIN_RD;
            end
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
          r_m_last  <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign o_s_ready      = r_s_ready;
  assign o_m_valid      = r_m_valid;
  assign o_m_data       = r_m_data;
  assign o_m_last       = r_m_last;
  assign o_busy         = r_busy;
  assign o_words_stored = r_words_stored;
  assign o_state        = r_state;

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stream_ctrl
//
// Drives mem_stream_ctrl against a behavioural model of the single-port
// synchronous memory. A command/fill vector table covers the control corner
// cases; hand-written sequences cover drain latency, backpressure, a full
// 256-word fill/drain and reset in the middle of a drain. Expected writes and
// expected output words are queued when stimulus is driven and popped by
// negedge monitors as the design produces them.
// -----------------------------------------------------------------------------
module tb_mem_stream_ctrl;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int ADDR  = 8;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_FILL = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd4;

  logic             clk;
  logic             rst;
  logic             i_fill_start;
  logic             i_drain_start;
  logic             i_s_valid;
  logic [WIDTH-1:0] i_s_data;
  logic             i_s_last;
  logic             o_s_ready;
  logic             o_m_valid;
  logic [WIDTH-1:0] o_m_data;
  logic             o_m_last;
  logic             i_m_ready;
  logic             o_busy;
  logic [ADDR:0]    o_words_stored;
  logic [ADDR-1:0]  o_mem_addr;
  logic [WIDTH-1:0] o_mem_wdata;
  logic             o_mem_wrbar;
  logic [WIDTH-1:0] mem_rdata;
  logic [2:0]       o_state;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH:0]        exp_q[$];   // {last, data} expected on m_*
  logic [ADDR+WIDTH-1:0] wr_q[$];    // {addr, data} expected memory writes
  logic [WIDTH-1:0]      mdl [DEPTH];
  logic [WIDTH-1:0]      mem_arr [DEPTH];

  mem_stream_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fill_start   (i_fill_start),
    .i_drain_start  (i_drain_start),
    .i_s_valid      (i_s_valid),
    .i_s_data       (i_s_data),
    .i_s_last       (i_s_last),
    .o_s_ready      (o_s_ready),
    .o_m_valid      (o_m_valid),
    .o_m_data       (o_m_data),
    .o_m_last       (o_m_last),
    .i_m_ready      (i_m_ready),
    .o_busy         (o_busy),
    .o_words_stored (o_words_stored),
    .o_mem_addr     (o_mem_addr),
    .o_mem_wdata    (o_mem_wdata),
    .o_mem_wrbar    (o_mem_wrbar),
    .i_mem_rdata    (mem_rdata),
    .o_state        (o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  always @(posedge clk) begin
    if (o_mem_wrbar) mem_arr[o_mem_addr] <= o_mem_wdata;
    else             mem_rdata <= mem_arr[o_mem_addr];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboards (sampled on negedge) ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (o_m_valid && i_m_ready) begin
        if (exp_q.size() == 0) begin
          chk("m_unexpected_word", {31'd0, o_m_last, o_m_data}, 64'h0);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          chk("m_word", {31'd0, o_m_last, o_m_data}, {31'd0, e});
        end
      end
      if (o_mem_wrbar) begin
        if (wr_q.size() == 0) begin
          chk("mem_unexpected_write", {24'd0, o_mem_addr, o_mem_wdata}, 64'h0);
        end else begin
          logic [ADDR+WIDTH-1:0] w;
          w = wr_q.pop_front();
          chk("mem_write", {24'd0, o_mem_addr, o_mem_wdata}, {24'd0, w});
        end
      end
      if (o_s_ready || o_m_valid) chk("s_ready_m_valid_exclusive", {63'd0, o_s_ready & o_m_valid}, 64'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_drain();
    i_drain_start = 1'b1;
    tick();
    i_drain_start = 1'b0;
  endtask

  task automatic do_fill(input int n, input bit use_last);
    i_fill_start = 1'b1;
    tick();
    i_fill_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      logic [31:0] iv;
      iv = i;
      i_s_valid = 1'b1;
      i_s_data  = $urandom;
      mdl[i]    = i_s_data;
      i_s_last  = use_last && (i == n - 1);
      wr_q.push_back({iv[ADDR-1:0], i_s_data});
      if (i == n - 1) chk("fill_s_ready_before_last", {63'd0, o_s_ready}, 64'd1);
      tick();
    end
    i_s_valid = 1'b0;
    i_s_last  = 1'b0;
    chk("fill_words_stored", {55'd0, o_words_stored}, n);
    chk("fill_s_ready_after", {63'd0, o_s_ready}, 64'd0);
    chk("fill_state_idle", {61'd0, o_state}, {61'd0, S_IDLE});
    chk("fill_busy_after", {63'd0, o_busy}, 64'd0);
    chk("fill_writes_done", wr_q.size(), 64'd0);
  endtask

  task automatic push_drain(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), mdl[i]});
  endtask

  task automatic wait_drain(input int budget, input bit rnd);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      if (rnd) i_m_ready = 1'($urandom_range(0, 1));
      tick();
      c++;
    end
    i_m_ready = 1'b1;
    chk("drain_complete", exp_q.size(), 64'd0);
    chk("drain_busy_after", {63'd0, o_busy}, 64'd0);
    chk("drain_state_idle", {61'd0, o_state}, {61'd0, S_IDLE});
    exp_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        fill_start;
    logic        drain_start;
    logic        s_valid;
    logic        s_last;
    logic [31:0] s_data;
    logic        exp_wr;
    logic [7:0]  exp_waddr;
    logic [2:0]  exp_state;
    logic        exp_busy;
    logic        exp_s_ready;
    logic [8:0]  exp_ws;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    int c;

    // fs ds sv sl data wr waddr | state busy s_ready words_stored (after edge)
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, S_IDLE, 1'b0, 1'b0, 9'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, S_FILL, 1'b1, 1'b1, 9'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h11111111, 1'b1, 8'd0, S_FILL, 1'b1, 1'b1, 9'd1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'd0, S_FILL, 1'b1, 1'b1, 9'd1};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h22222222, 1'b1, 8'd1, S_FILL, 1'b1, 1'b1, 9'd2};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h33333333, 1'b1, 8'd2, S_FILL, 1'b1, 1'b1, 9'd3};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h44444444, 1'b1, 8'd3, S_IDLE, 1'b0, 1'b0, 9'd4};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hdeadbeef, 1'b0, 8'd0, S_IDLE, 1'b0, 1'b0, 9'd4};

    rst = 1'b1;
    i_fill_start = 1'b0; i_drain_start = 1'b0;
    i_s_valid = 1'b0; i_s_data = '0; i_s_last = 1'b0; i_m_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // ---- reset asserted mid-cycle while idle ----
    #3 rst = 1'b1;
    #1;
    chk("rst_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_s_ready", {63'd0, o_s_ready}, 64'd0);
    chk("rst_m_valid", {63'd0, o_m_valid}, 64'd0);
    chk("rst_outputs_or", {31'd0, o_m_data | o_mem_wdata, o_mem_addr != 0 || o_mem_wrbar || o_m_last}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("rst_release_busy", {63'd0, o_busy}, 64'd0);
    chk("rst_release_words", {55'd0, o_words_stored}, 64'd0);
    chk("rst_release_state", {61'd0, o_state}, {61'd0, S_IDLE});

    // ---- table: command corner cases and short fill ----
    for (int i = 0; i < 8; i++) begin
      i_fill_start  = vecs[i].fill_start;
      i_drain_start = vecs[i].drain_start;
      i_s_valid     = vecs[i].s_valid;
      i_s_last      = vecs[i].s_last;
      i_s_data      = vecs[i].s_data;
      if (vecs[i].exp_wr) wr_q.push_back({vecs[i].exp_waddr, vecs[i].s_data});
      tick();
      chk($sformatf("vec%0d_state", i), {61'd0, o_state}, {61'd0, vecs[i].exp_state});
      chk($sformatf("vec%0d_busy", i), {63'd0, o_busy}, {63'd0, vecs[i].exp_busy});
      chk($sformatf("vec%0d_s_ready", i), {63'd0, o_s_ready}, {63'd0, vecs[i].exp_s_ready});
      chk($sformatf("vec%0d_words", i), {55'd0, o_words_stored}, {55'd0, vecs[i].exp_ws});
    end
    i_fill_start = 1'b0; i_drain_start = 1'b0;
    i_s_valid = 1'b0; i_s_last = 1'b0; i_s_data = '0;
    chk("short_fill_writes_done", wr_q.size(), 64'd0);
    mdl[0] = 32'h11111111; mdl[1] = 32'h22222222;
    mdl[2] = 32'h33333333; mdl[3] = 32'h44444444;

    // ---- short drain: first m_valid three cycles after the pulse ----
    push_drain(4);
    i_m_ready = 1'b1;
    pulse_drain();
    chk("drain_rd_state", {61'd0, o_state}, {61'd0, S_RD});
    lat = 1;
    while (!o_m_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("drain_first_latency", lat, 64'd3);
    wait_drain(60, 1'b0);

    // ---- backpressure, plus fill_start during drain ignored ----
    push_drain(4);
    i_m_ready = 1'b0;
    pulse_drain();
    c = 0;
    while (!o_m_valid && c < 20) begin
      tick();
      c++;
    end
    chk("bp_valid_seen", {63'd0, o_m_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      i_fill_start = (k == 2);
      tick();
      chk("bp_m_valid", {63'd0, o_m_valid}, 64'd1);
      chk("bp_m_data", {32'd0, o_m_data}, {32'd0, 32'h11111111});
      chk("bp_m_last", {63'd0, o_m_last}, 64'd0);
      chk("bp_mem_addr", {56'd0, o_mem_addr}, 64'd0);
      chk("bp_state", {61'd0, o_state}, {61'd0, S_OUT});
    end
    i_fill_start = 1'b0;
    chk("bp_words_kept", {55'd0, o_words_stored}, 64'd4);
    i_m_ready = 1'b1;
    wait_drain(60, 1'b0);

    // ---- full fill without s_last, then drain with random backpressure ----
    do_fill(DEPTH, 1'b0);
    push_drain(DEPTH);
    pulse_drain();
    wait_drain(DEPTH * 12, 1'b1);

    // ---- reset in the middle of a drain, at word 2 of 4 ----
    do_fill(4, 1'b1);
    push_drain(4);
    i_m_ready = 1'b1;
    pulse_drain();
    c = 0;
    while (!(o_m_valid && exp_q.size() == 3) && c < 40) begin
      tick();
      c++;
    end
    chk("mid_drain_word2_seen", {63'd0, o_m_valid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", {63'd0, o_m_valid}, 64'd0);
    chk("mid_rst_m_data", {32'd0, o_m_data}, 64'd0);
    chk("mid_rst_mem_addr", {56'd0, o_mem_addr}, 64'd0);
    chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("mid_rst_words", {55'd0, o_words_stored}, 64'd0);
    chk("mid_rst_state", {61'd0, o_state}, {61'd0, S_IDLE});

    // ---- fresh fill/drain after the reset ----
    do_fill(3, 1'b1);
    push_drain(3);
    pulse_drain();
    wait_drain(80, 1'b1);

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stream_ctrl.md
# mem_stream_ctrl

Sequencing controller that sits directly upstream of the single-port synchronous `memory` block (32-bit × 256, `wrbar`=1 write, `wrbar`=0 read). It accepts a valid/ready write stream and stores the words at consecutive addresses from 0. On command it reads the stored words back in order and presents them on a valid/ready output stream with a last-word marker. It replaces hand-driven address/data/`wrbar` sequencing with a handshaked fill/drain engine.

## Interface
- `WIDTH`, 32, data word width
- `DEPTH`, 256, number of memory words
- `ADDR`, 8, address width; DEPTH = 2^ADDR
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `fill_start`  in  1  single-cycle pulse: begin write stream at address 0
- `drain_start`  in  1  single-cycle pulse: begin readback from address 0
- `s_valid`  in  1  input word valid
- `s_data`  in  WIDTH  input word
- `s_last`  in  1  marks final input word (qualified by `s_valid`)
- `s_ready`  out  1  controller accepts an input word this cycle
- `m_valid`  out  1  output word valid
- `m_data`  out  WIDTH  output word
- `m_last`  out  1  output word is the last stored word
- `m_ready`  in  1  downstream accepts the output word
- `busy`  out  1  state ≠ IDLE
- `words_stored`  out  ADDR+1  number of words written by the last fill (0..DEPTH)
- `mem_addr`  out  ADDR  to memory `addr`
- `mem_wdata`  out  WIDTH  to memory `wdata`
- `mem_wrbar`  out  1  to memory `wrbar`; 1 = write
- `mem_rdata`  in  WIDTH  from memory `rdata`; registered, valid the cycle after a read address is presented

## Operation
- States: IDLE, FILL, DRAIN_RD, DRAIN_CAP, DRAIN_OUT.
- IDLE:
  - `fill_start` → FILL; clears `wptr` and `words_stored`.
  - Otherwise, `drain_start` with `words_stored` > 0 → DRAIN_RD; clears `rptr`.
  - `drain_start` with `words_stored` = 0 is ignored.
  - `fill_start` and `drain_start` in the same cycle: fill wins.
  - Start pulses received in any non-IDLE state are ignored.
- FILL:
  - `s_ready`=1.
  - Accept = `s_valid`&`s_ready`. On accept, combinationally: `mem_addr`=`wptr`, `mem_wdata`=`s_data`, `mem_wrbar`=1. The memory writes on that edge; `wptr`++ and `words_stored`++.
  - Leave to IDLE after accepting the word with `s_last`=1, or the word at `wptr`=DEPTH-1 (`words_stored` becomes DEPTH; `wptr` never wraps).
  - Cycles with no accept drive `mem_wrbar`=0.
- DRAIN_RD: `mem_addr`=`rptr`, `mem_wrbar`=0 → DRAIN_CAP.
- DRAIN_CAP: address held; `m_data` <= `mem_rdata` at end of cycle → DRAIN_OUT.
- DRAIN_OUT:
  - `m_valid`=1. `m_last`=1 iff `rptr` = `words_stored`-1.
  - `m_data`, `m_last` and `mem_addr` are held stable until `m_valid`&`m_ready`.
  - On handshake: if `m_last`, go to IDLE; else `rptr`++ and go to DRAIN_RD.
- Defaults outside the cases above: `mem_addr`=0, `mem_wdata`=0, `mem_wrbar`=0, `s_ready`=0, `m_valid`=0, `m_last`=0.
- Stored data persists across drains; repeated drains return the same stream.
- Reset (any time, including mid-fill or mid-drain):
  - state=IDLE, `wptr`=`rptr`=0, `words_stored`=0, `m_data`=0.
  - All outputs go to their defaults and `busy`=0.
  - An in-progress transfer is abandoned. Memory contents are not cleared.

## Timing
- Write: zero added latency. A word accepted in cycle N is written at the rising edge ending cycle N. Throughput is 1 word/cycle.
- Read: with `drain_start` in cycle N, DRAIN_RD is N+1, DRAIN_CAP is N+2, and the first `m_valid` is in N+3.
- With `m_ready` held at 1, each word takes 3 cycles: 1/3 words per cycle.
- `busy` rises the cycle after an accepted start pulse. It falls the cycle after the final write accept or the final output handshake.
- `s_ready` and `m_valid` are never high in the same cycle.

## Test plan
- Reset: assert `rst` mid-cycle while idle. All outputs are 0 immediately (async). After release, `busy`=0 and `words_stored`=0.
- Short fill/drain: write 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `s_last` on the 4th. Required: `mem_wrbar`=1 at addresses 0..3, `words_stored`=4, return to IDLE. Then `drain_start` with `m_ready`=1. Required: the same 4 words in order, first `m_valid` 3 cycles after the pulse, `m_last` only on 0x44444444.
- Full fill: 256 `$random` words with no `s_last`. Required: `s_ready` drops after the 256th, `words_stored`=256. Drain all 256 words and compare; `m_last` on the word from address 255.
- Backpressure: hold `m_ready`=0 for 5 cycles during DRAIN_OUT. Required: `m_valid`, `m_data`, `m_last` and `mem_addr` stay stable, and `rptr` does not advance.
- Command corner cases:
  - `drain_start` with `words_stored`=0: no state change.
  - `fill_start` and `drain_start` together: FILL is entered.
  - `fill_start` during DRAIN: ignored.
- Reset mid-drain at word 2 of 4: outputs return to reset values and `words_stored`=0. A new fill/drain then completes correctly.
